pipelined_adder_unit: RTL and testbench

Parametrised, pipelined add/subtract unit with registered outputs, valid/ready handshakes on both sides, result flags and a windowed operation counter. It generalises the 3-bit registered ripple adder to WIDTH bits split into STAGES carry-propagating segments, adds subtract mode and backpressure, and replaces the free-running cycle counter with a counter of delivered results. It sits between the top-level pin wrapper and the operand/result ports.

---
 rtl/pau_pkg.sv | 11 +
 rtl/adder_segment.sv | 29 ++
 rtl/pipelined_adder_unit.sv | 131 +++++++++++++
 tb/tb_pipelined_adder_unit.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pau_pkg.sv
// Shared constants and helpers for the pipelined add/subtract unit.
package pau_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  function automatic int seg_width(input int width, input int stages);
    return width / stages;
  endfunction

endpackage

// File: rtl/adder_segment.sv
// Combinational ripple-carry segment; also exposes the carry into its MSB
// so the top level can derive signed overflow from the final segment.
module adder_segment #(
  parameter int SEG_W = 4
) (
  input  logic [SEG_W-1:0] a,
  input  logic [SEG_W-1:0] b,
  input  logic             cin,
  output logic [SEG_W-1:0] sum,
  output logic             cout,
  output logic             cmsb
);

  logic [SEG_W:0] carry;

  always_comb begin
    carry    = '0;
    sum      = '0;
    carry[0] = cin;
    for (int i = 0; i < SEG_W; i++) begin
      sum[i]       = a[i] ^ b[i] ^ carry[i];
      carry[i+1]   = (a[i] & b[i]) | (a[i] & carry[i]) | (b[i] & carry[i]);
    end
  end

  assign cout = carry[SEG_W];
  assign cmsb = carry[SEG_W-1];

endmodule

// File: rtl/pipelined_adder_unit.sv
// Segmented pipelined add/subtract unit with valid/ready handshakes,
// result flags and a windowed count of delivered results.
module pipelined_adder_unit
  import pau_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int STAGES    = 2,
  parameter int MAX_COUNT = 1000,
  parameter int CW        = $clog2(MAX_COUNT)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero,
  output logic [CW-1:0]    op_count,
  output logic             window_done
);

  localparam int SW = seg_width(WIDTH, STAGES);

  logic stall;
  logic [WIDTH-1:0] b_in;
  logic c_in;

  logic [STAGES-1:0]            vld_q, cy_q;
  logic [STAGES-1:0][WIDTH-1:0] a_q, b_q, sum_q;
  logic                         cmsb_q;

  logic [STAGES-1:0]            v_src, c_src;
  logic [STAGES-1:0][WIDTH-1:0] a_src, b_src, sum_nxt;
  logic [STAGES-1:0][SW-1:0]    seg_sum;
  logic [STAGES-1:0]            seg_cout, seg_cmsb;

  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;

  // Subtract is folded into the operands on entry: A + ~B + !borrow.
  assign b_in = (in_mode == MODE_SUB) ? ~in_b : in_b;
  assign c_in = (in_mode == MODE_SUB) ? ~in_cin : in_cin;

  always_comb begin
    v_src    = '0;
    c_src    = '0;
    a_src    = '0;
    b_src    = '0;
    v_src[0] = in_valid;
    c_src[0] = c_in;
    a_src[0] = in_a;
    b_src[0] = b_in;
    for (int s = 1; s < STAGES; s++) begin
      v_src[s] = vld_q[s-1];
      c_src[s] = cy_q[s-1];
      a_src[s] = a_q[s-1];
      b_src[s] = b_q[s-1];
    end
  end

  for (genvar s = 0; s < STAGES; s++) begin : g_seg
    adder_segment #(.SEG_W(SW)) u_seg (
      .a    (a_src[s][s*SW +: SW]),
      .b    (b_src[s][s*SW +: SW]),
      .cin  (c_src[s]),
      .sum  (seg_sum[s]),
      .cout (seg_cout[s]),
      .cmsb (seg_cmsb[s])
    );
  end

  // Each stage writes its slice over the partial sum carried from the stage before.
  always_comb begin
    sum_nxt = '0;
    for (int s = 1; s < STAGES; s++) begin
      sum_nxt[s] = sum_q[s-1];
    end
    for (int s = 0; s < STAGES; s++) begin
      sum_nxt[s][s*SW +: SW] = seg_sum[s];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q  <= '0;
      cy_q   <= '0;
      cmsb_q <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      sum_q  <= '0;
    end else if (!stall) begin
      vld_q  <= v_src;
      cy_q   <= seg_cout;
      cmsb_q <= seg_cmsb[STAGES-1];
      a_q    <= a_src;
      b_q    <= b_src;
      sum_q  <= sum_nxt;
    end
  end

  assign out_valid = vld_q[STAGES-1];
  assign out_sum   = sum_q[STAGES-1];
  assign out_cout  = cy_q[STAGES-1];
  assign out_ovf   = cmsb_q ^ cy_q[STAGES-1];
  assign out_zero  = (out_sum == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      op_count    <= '0;
      window_done <= 1'b0;
    end else begin
      window_done <= 1'b0;
      if (out_valid && out_ready) begin
        if (op_count == CW'(MAX_COUNT - 1)) begin
          op_count    <= '0;
          window_done <= 1'b1;
        end else begin
          op_count <= op_count + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_pipelined_adder_unit.sv
// Scoreboard bench: a 2-stage unit with a 4-result window, plus 1- and
// 8-stage units exercised with random add/sub traffic.
module tb_pipelined_adder_unit;
  import pau_pkg::*;

  typedef struct packed {
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
    logic       zero;
  } res_t;

  typedef struct packed {
    res_t        r;
    int unsigned acc;
  } tag_t;

  typedef struct packed {
    logic dlv;
    logic acc;
    logic rdy;
    logic vld;
    res_t got;
  } obs_t;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       mode;
    res_t       exp;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic       in_valid = 1'b0, in_cin = 1'b0, in_mode = 1'b0, out_ready = 1'b1;
  logic [7:0] in_a = '0, in_b = '0;
  logic       in_ready, out_valid, out_cout, out_ovf, out_zero, window_done;
  logic [7:0] out_sum;
  logic [1:0] op_count;

  logic       x_valid = 1'b0, x_cin = 1'b0, x_mode = 1'b0;
  logic [7:0] x_a = '0, x_b = '0;
  logic       y1_rdy, y1_vld, y1_cout, y1_ovf, y1_zero, y1_wd;
  logic [7:0] y1_sum;
  logic [9:0] y1_cnt;
  logic       y8_rdy, y8_vld, y8_cout, y8_ovf, y8_zero, y8_wd;
  logic [7:0] y8_sum;
  logic [9:0] y8_cnt;

  pipelined_adder_unit #(.WIDTH(8), .STAGES(2), .MAX_COUNT(4)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_cout(out_cout), .out_ovf(out_ovf), .out_zero(out_zero),
    .op_count(op_count), .window_done(window_done)
  );

  pipelined_adder_unit #(.WIDTH(8), .STAGES(1)) u_s1 (
    .clk(clk), .reset(reset), .in_valid(x_valid), .in_ready(y1_rdy),
    .in_a(x_a), .in_b(x_b), .in_cin(x_cin), .in_mode(x_mode),
    .out_valid(y1_vld), .out_ready(1'b1), .out_sum(y1_sum),
    .out_cout(y1_cout), .out_ovf(y1_ovf), .out_zero(y1_zero),
    .op_count(y1_cnt), .window_done(y1_wd)
  );

  pipelined_adder_unit #(.WIDTH(8), .STAGES(8)) u_s8 (
    .clk(clk), .reset(reset), .in_valid(x_valid), .in_ready(y8_rdy),
    .in_a(x_a), .in_b(x_b), .in_cin(x_cin), .in_mode(x_mode),
    .out_valid(y8_vld), .out_ready(1'b1), .out_sum(y8_sum),
    .out_cout(y8_cout), .out_ovf(y8_ovf), .out_zero(y8_zero),
    .op_count(y8_cnt), .window_done(y8_wd)
  );

  int n_cmp = 0;
  int n_bad = 0;
  res_t q[$];
  tag_t q1[$], q8[$];

  function automatic res_t model(input logic [7:0] a, input logic [7:0] b,
                                 input logic cin, input logic mode);
    res_t r;
    logic [8:0] full;
    int s;
    if (mode == MODE_SUB) begin
      full = 9'h100 + {1'b0, a} - {1'b0, b} - {8'd0, cin};
      s = int'($signed(a)) - int'($signed(b)) - int'(cin);
    end else begin
      full = {1'b0, a} + {1'b0, b} + {8'd0, cin};
      s = int'($signed(a)) + int'($signed(b)) + int'(cin);
    end
    r.sum  = full[7:0];
    r.cout = full[8];
    r.ovf  = (s > 127) || (s < -128);
    r.zero = (full[7:0] == 8'h00);
    return r;
  endfunction

  // Samples the main unit mid-cycle, records accepted beats, advances one edge.
  task automatic tick(output obs_t o);
    #1;
    o.dlv = out_valid && out_ready;
    o.acc = in_valid && in_ready;
    o.rdy = in_ready;
    o.vld = out_valid;
    o.got = {out_sum, out_cout, out_ovf, out_zero};
    if (o.acc && !reset) q.push_back(model(in_a, in_b, in_cin, in_mode));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    x_valid = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    q.delete();
    q1.delete();
    q8.delete();
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_sum !== 8'h00) begin n_bad++; $display("FAIL reset_out_sum: got %h want 00", out_sum); end
    n_cmp++; if ({out_cout, out_ovf, out_zero} !== 3'b001) begin n_bad++; $display("FAIL reset_flags: got %b want 001", {out_cout, out_ovf, out_zero}); end
    n_cmp++; if (op_count !== 2'd0 || window_done !== 1'b0) begin n_bad++; $display("FAIL reset_counter: got %0d/%b want 0/0", op_count, window_done); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_vectors();
    vec_t v[6];
    obs_t o;
    int n;
    logic seen;
    v[0] = {8'h7F, 8'h01, 1'b0, MODE_ADD, {8'h80, 1'b0, 1'b1, 1'b0}};
    v[1] = {8'hFF, 8'h01, 1'b0, MODE_ADD, {8'h00, 1'b1, 1'b0, 1'b1}};
    v[2] = {8'h05, 8'h07, 1'b0, MODE_SUB, {8'hFE, 1'b0, 1'b0, 1'b0}};
    v[3] = {8'h80, 8'h01, 1'b0, MODE_SUB, {8'h7F, 1'b1, 1'b1, 1'b0}};
    v[4] = {8'h10, 8'h03, 1'b1, MODE_SUB, {8'h0C, 1'b1, 1'b0, 1'b0}};
    v[5] = {8'h0F, 8'h00, 1'b1, MODE_ADD, {8'h10, 1'b0, 1'b0, 1'b0}};
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_a = v[i].a; in_b = v[i].b; in_cin = v[i].cin; in_mode = v[i].mode;
      tick(o);
      in_valid = 1'b0;
      n = 0;
      seen = 1'b0;
      while (!seen && n < 8) begin
        tick(o);
        n++;
        if (o.dlv) begin
          seen = 1'b1;
          void'(q.pop_front());
          n_cmp++; if (o.got !== v[i].exp) begin n_bad++; $display("FAIL vec%0d_result: got %h want %h", i, o.got, v[i].exp); end
          n_cmp++; if (n != 2) begin n_bad++; $display("FAIL vec%0d_latency: got %0d want 2", i, n); end
        end
      end
      if (!seen) begin n_cmp++; n_bad++; $display("FAIL vec%0d_timeout: got no result want one", i); end
    end
  endtask

  task automatic test_stall();
    obs_t o;
    res_t e;
    int idx = 0, got_n = 0, c = 0;
    logic held_set = 1'b0;
    logic [7:0] held = '0;
    in_b = 8'h10; in_cin = 1'b0; in_mode = MODE_ADD;
    while (got_n < 6 && c < 40) begin
      out_ready = !(c >= 4 && c <= 6);
      in_valid = (idx < 6);
      in_a = 8'(idx + 1);
      tick(o);
      if (o.acc) idx++;
      if (o.vld && !out_ready) begin
        n_cmp++; if (o.rdy !== 1'b0) begin n_bad++; $display("FAIL stall_in_ready: got %b want 0", o.rdy); end
        if (held_set) begin
          n_cmp++; if (o.got.sum !== held) begin n_bad++; $display("FAIL stall_hold: got %h want %h", o.got.sum, held); end
        end
        held = o.got.sum;
        held_set = 1'b1;
      end
      if (o.dlv) begin
        e = q.pop_front();
        n_cmp++; if (o.got !== e || o.got.sum !== 8'(8'h11 + got_n)) begin n_bad++; $display("FAIL stream_order: got %h want %h", o.got.sum, 8'(8'h11 + got_n)); end
        got_n++;
      end
      c++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    n_cmp++; if (got_n != 6 || q.size() != 0) begin n_bad++; $display("FAIL stream_count: got %0d left %0d want 6 left 0", got_n, q.size()); end
    n_cmp++; if (!held_set) begin n_bad++; $display("FAIL stall_seen: got 0 want 1"); end
  endtask

  task automatic test_window();
    obs_t o;
    res_t e;
    int sent = 0, dl = 0, c = 0, pulses = 0;
    logic [1:0] exp_cnt = 2'd0;
    logic wrap;
    do_reset();
    in_mode = MODE_ADD; in_b = 8'h01; in_cin = 1'b0;
    while (dl < 5 && c < 30) begin
      in_valid = (sent < 5);
      in_a = 8'(8'h20 + sent);
      tick(o);
      if (o.acc) sent++;
      wrap = 1'b0;
      if (o.dlv) begin
        e = q.pop_front();
        n_cmp++; if (o.got !== e) begin n_bad++; $display("FAIL window_result: got %h want %h", o.got, e); end
        dl++;
        exp_cnt = exp_cnt + 2'd1;
        wrap = (exp_cnt == 2'd0);
      end
      n_cmp++; if (op_count !== exp_cnt) begin n_bad++; $display("FAIL op_count: got %0d want %0d", op_count, exp_cnt); end
      n_cmp++; if (window_done !== wrap) begin n_bad++; $display("FAIL window_done: got %b want %b", window_done, wrap); end
      if (window_done === 1'b1) pulses++;
      c++;
    end
    in_valid = 1'b0;
    n_cmp++; if (dl != 5 || pulses != 1) begin n_bad++; $display("FAIL window_totals: got %0d/%0d want 5/1", dl, pulses); end
  endtask

  task automatic test_reset_flush();
    obs_t o;
    int dl = 0, c = 0, extra = 0;
    do_reset();
    in_mode = MODE_ADD; in_b = 8'h02; in_cin = 1'b0; in_a = 8'h40;
    in_valid = 1'b1;
    while (dl < 3 && c < 20) begin
      in_valid = (c < 3);
      tick(o);
      if (o.dlv) dl++;
      c++;
    end
    in_valid = 1'b0;
    n_cmp++; if (op_count !== 2'd3) begin n_bad++; $display("FAIL flush_pre_count: got %0d want 3", op_count); end
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_a = 8'h55;
    tick(o);
    in_a = 8'h66;
    tick(o);
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL flush_in_flight: got %b want 1", out_valid); end
    reset = 1'b1;
    tick(o);
    reset = 1'b0;
    q.delete();
    n_cmp++; if (out_valid !== 1'b0 || op_count !== 2'd0) begin n_bad++; $display("FAIL flush_state: got %b/%0d want 0/0", out_valid, op_count); end
    n_cmp++; if (out_sum !== 8'h00 || out_zero !== 1'b1) begin n_bad++; $display("FAIL flush_sum: got %h/%b want 00/1", out_sum, out_zero); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL flush_in_ready: got %b want 1", in_ready); end
    out_ready = 1'b1;
    repeat (6) begin
      tick(o);
      if (o.dlv) extra++;
    end
    n_cmp++; if (extra != 0 || op_count !== 2'd0) begin n_bad++; $display("FAIL flush_ghosts: got %0d/%0d want 0/0", extra, op_count); end
  endtask

  task automatic test_random_stages();
    tag_t t;
    res_t r;
    int n1 = 0, n8 = 0;
    for (int it = 0; it < 220; it++) begin
      x_valid = (it < 200) && ($urandom_range(0, 3) != 0);
      x_a = 8'($urandom);
      x_b = 8'($urandom);
      x_cin = 1'($urandom_range(0, 1));
      x_mode = 1'($urandom_range(0, 1));
      #1;
      if (y1_vld) begin
        n_cmp++;
        if (q1.size() == 0) begin n_bad++; $display("FAIL s1_spurious: got %h want none", y1_sum); end
        else begin
          t = q1.pop_front();
          if ({y1_sum, y1_cout, y1_ovf, y1_zero} !== t.r || it - int'(t.acc) != 1) begin
            n_bad++; $display("FAIL s1_result: got %h lat %0d want %h lat 1", {y1_sum, y1_cout, y1_ovf, y1_zero}, it - int'(t.acc), t.r);
          end
        end
        n1++;
      end
      if (y8_vld) begin
        n_cmp++;
        if (q8.size() == 0) begin n_bad++; $display("FAIL s8_spurious: got %h want none", y8_sum); end
        else begin
          t = q8.pop_front();
          if ({y8_sum, y8_cout, y8_ovf, y8_zero} !== t.r || it - int'(t.acc) != 8) begin
            n_bad++; $display("FAIL s8_result: got %h lat %0d want %h lat 8", {y8_sum, y8_cout, y8_ovf, y8_zero}, it - int'(t.acc), t.r);
          end
        end
        n8++;
      end
      if (x_valid) begin
        n_cmp++; if (y1_rdy !== 1'b1 || y8_rdy !== 1'b1) begin n_bad++; $display("FAIL aux_ready: got %b%b want 11", y1_rdy, y8_rdy); end
        r = model(x_a, x_b, x_cin, x_mode);
        t.r = r;
        t.acc = it;
        q1.push_back(t);
        q8.push_back(t);
      end
      @(posedge clk);
      #1;
    end
    x_valid = 1'b0;
    n_cmp++; if (q1.size() != 0 || q8.size() != 0) begin n_bad++; $display("FAIL aux_drain: got %0d/%0d left want 0/0", q1.size(), q8.size()); end
    n_cmp++; if (y1_cnt !== 10'(n1 % 1000) || y8_cnt !== 10'(n8 % 1000)) begin n_bad++; $display("FAIL aux_count: got %0d/%0d want %0d/%0d", y1_cnt, y8_cnt, n1, n8); end
    n_cmp++; if (y1_wd !== 1'b0 || y8_wd !== 1'b0) begin n_bad++; $display("FAIL aux_window: got %b%b want 00", y1_wd, y8_wd); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_vectors();
    test_stall();
    test_window();
    test_reset_flush();
    test_random_stages();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
